// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg                                                             |
// | Shared 7-segment types, blank constant and hex-to-segment encoder.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // dp is the lit request (1 = on); result is active-low {dp,g,f,e,d,c,b,a}
  function automatic seg_t hex2seg(logic [3:0] h, logic dp);
    logic [6:0] abc;
    case (h)
      4'h0:    abc = 7'h3F;
      4'h1:    abc = 7'h06;
      4'h2:    abc = 7'h5B;
      4'h3:    abc = 7'h4F;
      4'h4:    abc = 7'h66;
      4'h5:    abc = 7'h6D;
      4'h6:    abc = 7'h7D;
      4'h7:    abc = 7'h07;
      4'h8:    abc = 7'h7F;
      4'h9:    abc = 7'h6F;
      4'hA:    abc = 7'h77;
      4'hB:    abc = 7'h7C;
      4'hC:    abc = 7'h39;
      4'hD:    abc = 7'h5E;
      4'hE:    abc = 7'h79;
      default: abc = 7'h71;
    endcase
    return ~{dp, abc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver_if                                                  |
// | Display data in, digit select / segments / frame strobe out.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seg7_scan_driver_if #(
  parameter int N_DIG = 8
);
  import seg7_pkg::*;

  logic               en;
  logic [4*N_DIG-1:0] value;
  logic [N_DIG-1:0]   dot;
  logic [N_DIG-1:0]   cs;
  seg_t               seg;
  logic               frame_done;

  modport master (output en, value, dot, input cs, seg, frame_done);
  modport slave  (input en, value, dot, output cs, seg, frame_done);

endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_tick_gen                                                        |
// | Scan prescaler: one-clock tick every DIV clocks while en is high.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int             CW     = $clog2(DIV);
  localparam logic [CW-1:0]  c_last = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver                                                     |
// | N-digit common-anode scan driver with frame-aligned shadow register. |
// | Option: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int F_CLK  = 50000000,
  parameter int F_SCAN = 1000,
  parameter int N_DIG  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int DIV = F_CLK / F_SCAN;
  localparam int PW  = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [PW-1:0]    c_ptr_last = PW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] c_one      = N_DIG'(1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_gap  = 2'd1;
  localparam logic [1:0] c_st_show = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_ptr_nxt;
  logic               r_en_q;
  logic [4*N_DIG-1:0] r_val_sh;
  logic [N_DIG-1:0]   r_dot_sh;
  logic [N_DIG-1:0]   r_cs;
  seg_t               r_seg;
  logic               r_frame_done;

  logic               w_run;
  logic               w_rise;
  logic               w_tick;
  logic               w_wrap;
  logic               w_load;
  logic [3:0]         w_nib;
  logic               w_dp;
  seg_t               w_digit_seg;
  logic [N_DIG-1:0]   w_cs_d;
  seg_t               w_seg_d;

  // Prescaler is held clear on the enable edge so the first window is full length
  assign w_run  = bus.en & r_en_q;
  assign w_rise = bus.en & ~r_en_q;
  assign w_wrap = w_tick & (r_ptr == c_ptr_last);
  assign w_load = w_rise | w_wrap;

  scan_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    if (!bus.en) begin
      w_state_nxt = c_st_idle;
    end else if (w_rise || w_tick) begin
      w_state_nxt = c_st_gap;
    end else if (r_state == c_st_gap) begin
      w_state_nxt = c_st_show;
    end else if (r_state != c_st_show) begin
      w_state_nxt = c_st_gap;
    end
  end

  always_comb begin : p_ptr_next
    w_ptr_nxt = r_ptr;
    if (!bus.en || w_rise) begin
      w_ptr_nxt = '0;
    end else if (w_tick) begin
      w_ptr_nxt = w_wrap ? '0 : r_ptr + 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [N_DIG-1:0] w_blank_nxt;
  logic [N_DIG-1:0] r_blank;

  // Digit i blanks when it and every digit above it hold zero; digit 0 never blanks
  always_comb begin : p_blank_mask
    logic seen;
    seen        = 1'b0;
    w_blank_nxt = '0;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      seen           = seen | (bus.value[4*i +: 4] != 4'h0);
      w_blank_nxt[i] = ~seen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_blank_reg
    if (!rst_n) begin
      r_blank <= '0;
    end else if (w_load) begin
      r_blank <= w_blank_nxt;
    end
  end
`endif

  always_comb begin : p_digit
    w_nib       = r_val_sh[{r_ptr, 2'b00} +: 4];
    w_dp        = r_dot_sh[r_ptr];
    w_digit_seg = hex2seg(w_nib, w_dp);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (r_blank[r_ptr]) begin
      w_digit_seg = {~w_dp, 7'h7F};
    end
`endif
  end

  // Any transition into gap or idle blanks; a digit is only driven leaving the gap
  always_comb begin : p_output
    w_cs_d  = r_cs;
    w_seg_d = r_seg;
    if (w_state_nxt != c_st_show) begin
      w_cs_d  = '1;
      w_seg_d = SEG_BLANK;
    end else if (r_state == c_st_gap) begin
      w_cs_d  = ~(c_one << r_ptr);
      w_seg_d = w_digit_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_data_reg
    if (!rst_n) begin
      r_ptr        <= '0;
      r_en_q       <= 1'b0;
      r_val_sh     <= '0;
      r_dot_sh     <= '0;
      r_cs         <= '1;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_en_q       <= bus.en;
      r_cs         <= w_cs_d;
      r_seg        <= w_seg_d;
      r_frame_done <= w_wrap;
      if (w_load) begin
        r_val_sh <= bus.value;
        r_dot_sh <= bus.dot;
      end
    end
  end

  assign bus.cs         = r_cs;
  assign bus.seg        = r_seg;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_driver                                                  |
// | Directed scoreboard bench: 8 digits, tick every 8 clocks.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seg7_scan_driver;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg7_scan_driver_if #(.N_DIG(N)) bus ();

  seg7_scan_driver #(
    .F_CLK  (16),
    .F_SCAN (2),
    .N_DIG  (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cs;
    logic [7:0] seg;
    int         dig;
  } win_t;

  win_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   fd_count = 0;
  logic fd_prev  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [7:0] d, input int i);
    logic [6:0] a;
    a = enc(v[4*i +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic [31:0] hi;
      hi = v >> (4 * i);
      if (i > 0 && hi == 32'h0) a = 7'h00;
    end
`endif
    return ~{d[i], a};
  endfunction

  task automatic push_frame(input logic [31:0] v, input logic [7:0] d, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      win_t       w;
      logic [7:0] c;
      c     = 8'h01 << i;
      w.cs  = ~c;
      w.seg = exp_seg(v, d, i);
      w.dig = i;
      sb.push_back(w);
    end
  endtask

  // Returns at the negedge where the window has ended
  task automatic wait_window(output logic [7:0] wcs, output logic [7:0] wseg,
                             output int len, output time ts);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.cs === 8'hFF && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 40) else begin
      bad++;
      $error("FAIL window_timeout observed=%0d idle cycles expected=<40", n);
    end
    wcs  = bus.cs;
    wseg = bus.seg;
    ts   = $time;
    len  = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.cs !== wcs || bus.seg !== wseg) break;
      len++;
    end
  endtask

  task automatic check_windows(input int n, output time t_first);
    logic [7:0] wc, ws;
    int         wl;
    time        ts;
    t_first = 0;
    for (int k = 0; k < n; k++) begin
      win_t e;
      wait_window(wc, ws, wl, ts);
      if (k == 0) t_first = ts;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL sb_empty observed=window cs=%0h expected=no window", wc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("d%0d_cs", e.dig), {24'h0, wc}, {24'h0, e.cs});
        chk($sformatf("d%0d_seg", e.dig), {24'h0, ws}, {24'h0, e.seg});
        chk($sformatf("d%0d_len", e.dig), wl, 7);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) begin
      fd_count++;
      total++;
      assert (fd_prev !== 1'b1) else begin
        bad++;
        $error("FAIL fd_width observed=2+ cycles expected=1 cycle");
      end
    end
    fd_prev = bus.frame_done;
  end

  initial begin
    time  t0, t1, tr;
    int   fd_base;
    logic dark_ok;

    bus.en    = 1'b1;
    bus.value = 32'h0123_4567;
    bus.dot   = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", {24'h0, bus.cs}, 32'hFF);
    chk("rst_seg", {24'h0, bus.seg}, 32'hFF);
    chk("rst_fd", {31'h0, bus.frame_done}, 32'h0);
    rst_n = 1'b1;

    // Basic frame, then new value presented before the last window
    push_frame(32'h0123_4567, 8'h00, 0, 7);
    check_windows(7, t0);
    bus.value = 32'h1111_1111;
    check_windows(1, t0);

    // Mid-frame change must not tear the frame
    push_frame(32'h1111_1111, 8'h00, 0, 7);
    check_windows(1, t0);
    fd_base = fd_count;
    check_windows(3, t1);
    bus.value = 32'h2222_2222;
    check_windows(4, t1);
    push_frame(32'h2222_2222, 8'h00, 0, 7);
    check_windows(1, t1);
    chk("frame_len", 32'(t1 - t0), 32'd640);
    chk("fd_once", fd_count - fd_base, 1);
    check_windows(6, t1);
    bus.value = 32'h0;
    bus.dot   = 8'h04;
    check_windows(1, t1);

    // Decimal point on digit 2 only
    push_frame(32'h0, 8'h04, 0, 7);
    check_windows(7, t1);
    bus.value = 32'h0000_00A0;
    bus.dot   = 8'h00;
    check_windows(1, t1);

    // Leading-zero patterns
    push_frame(32'h0000_00A0, 8'h00, 0, 7);
    check_windows(7, t1);
    bus.value = 32'h0;
    check_windows(1, t1);

    // Disable during digit 5
    push_frame(32'h0, 8'h00, 0, 4);
    check_windows(5, t1);
    @(negedge clk);
    chk("d5_live_cs", {24'h0, bus.cs}, 32'hDF);
    repeat (2) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    chk("off_cs", {24'h0, bus.cs}, 32'hFF);
    chk("off_seg", {24'h0, bus.seg}, 32'hFF);
    dark_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.cs !== 8'hFF || bus.seg !== 8'hFF) dark_ok = 1'b0;
    end
    chk("off_hold", {31'h0, dark_ok}, 32'h1);

    // Re-enable: digit 0 with new value two clocks later, no frame strobe
    fd_base   = fd_count;
    bus.value = 32'h89AB_CDEF;
    bus.dot   = 8'h80;
    bus.en    = 1'b1;
    tr        = $time;
    push_frame(32'h89AB_CDEF, 8'h80, 0, 7);
    check_windows(1, t1);
    chk("en_latency", 32'(t1 - tr), 32'd20);
    chk("en_no_fd", fd_count - fd_base, 0);
    check_windows(5, t1);

    // Asynchronous reset inside the digit 6 window
    @(negedge clk);
    chk("d6_live_cs", {24'h0, bus.cs}, 32'hBF);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", {24'h0, bus.cs}, 32'hFF);
    chk("arst_seg", {24'h0, bus.seg}, 32'hFF);
    chk("arst_fd", {31'h0, bus.frame_done}, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tr    = $time;
    push_frame(32'h89AB_CDEF, 8'h80, 0, 1);
    check_windows(1, t0);
    chk("rst_restart", 32'(t0 - tr), 32'd20);
    check_windows(1, t1);
    chk("digit_period", 32'(t1 - t0), 32'd80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
